// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT sample loader.
// Holds width defaults, the loader FSM states and address reversal.
package fft_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  // Mirror the low `width` bits; the upper zero bits fall out of the shift.
  function automatic logic [31:0] bit_rev(
    input logic [31:0] value,
    input int          width
  );
    logic [31:0] full;
    full = {<<{value}};
    return full >> (32 - width);
  endfunction

endpackage

// File: rtl/bitrev_addr.sv
// Combinational W-bit address reversal for decimation-in-time ordering.
module bitrev_addr
  import fft_pkg::*;
#(
  parameter int W = ADDR_W_DEF
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] result
);

  assign result = W'(bit_rev(32'(value), W));

endmodule

// File: rtl/fft_sample_loader.sv
// Streams one frame of samples into FFT RAM, optionally bit-reversed,
// then holds frame_ready until the FFT core acknowledges the frame.
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BITREV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              read_write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_bus,
  output logic              bus_clr,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic [7:0]        frame_count
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] rev_count;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept;

  bitrev_addr #(.W(ADDR_W)) u_rev (
    .value (count),
    .result(rev_count)
  );

  assign wr_addr  = (BITREV != 0) ? rev_count : count;
  assign in_ready = (state == LOAD) && !reset;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      frame_count <= '0;
      read_write  <= 1'b0;
      bus_clr     <= 1'b1;
      address     <= '0;
      data_bus    <= '0;
      frame_ready <= 1'b0;
    end else begin
      // Bus is released unless this edge captures a sample.
      read_write <= 1'b0;
      bus_clr    <= 1'b1;
      data_bus   <= '0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            count <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            read_write <= 1'b1;
            bus_clr    <= 1'b0;
            data_bus   <= in_data;
            address    <= wr_addr;
            count      <= count + ADDR_W'(1);
            if (count == LAST) state <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle carries the final write; announce after it.
          if (!frame_ready) begin
            frame_ready <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end else if (frame_ack) begin
            frame_ready <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench: BITREV=1 and BITREV=0 loaders share one stimulus
// stream; the driver queues expected writes, a monitor retires them.
module tb_fft_sample_loader;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk = 0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        frame_ack;

  logic        rdy[2];
  logic        rw[2];
  logic [7:0]  ad[2];
  logic [15:0] db[2];
  logic        bc[2];
  logic        fr[2];
  logic [7:0]  fc[2];

  exp_t q[2][$];
  exp_t e;
  int   cyc = 0;
  int   mcnt;
  int   total = 0;
  int   passed = 0;
  bit   mon_en = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_sample_loader #(.ADDR_W(8), .DATA_W(16), .BITREV(1)) u_rev (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .read_write(rw[1]), .address(ad[1]), .data_bus(db[1]),
    .bus_clr(bc[1]), .frame_ready(fr[1]), .frame_ack(frame_ack),
    .frame_count(fc[1])
  );

  fft_sample_loader #(.ADDR_W(8), .DATA_W(16), .BITREV(0)) u_nat (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .read_write(rw[0]), .address(ad[0]), .data_bus(db[0]),
    .bus_clr(bc[0]), .frame_ready(fr[0]), .frame_ack(frame_ack),
    .frame_count(fc[0])
  );

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = v[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s at cycle %0d: got %0h want %0h",
               name, cyc, act, exp);
    else
      passed++;
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        if (q[k].size() > 0 && q[k][0].cyc < cyc) begin
          fail_now($sformatf("missed_write%0d", k));
          void'(q[k].pop_front());
        end
        if (rw[k] === 1'b1) begin
          if (q[k].size() == 0 || q[k][0].cyc != cyc) begin
            fail_now($sformatf("unexpected_write%0d", k));
          end else begin
            e = q[k].pop_front();
            chk($sformatf("addr%0d", k), 32'(ad[k]), 32'(e.addr));
            chk($sformatf("data%0d", k), 32'(db[k]), 32'(e.data));
            chk($sformatf("wr_bus_clr%0d", k), 32'(bc[k]), 0);
          end
        end else begin
          chk($sformatf("read_write%0d", k), 32'(rw[k]), 0);
          chk($sformatf("gap_bus_clr%0d", k), 32'(bc[k]), 1);
          chk($sformatf("gap_data%0d", k), 32'(db[k]), 0);
        end
      end
    end
  end

  task automatic both(input string name, input int sel,
                      input logic [31:0] exp);
    for (int k = 0; k < 2; k++) begin
      case (sel)
        0: chk($sformatf("%s%0d", name, k), 32'(rdy[k]), exp);
        1: chk($sformatf("%s%0d", name, k), 32'(fr[k]), exp);
        2: chk($sformatf("%s%0d", name, k), 32'(fc[k]), exp);
        default: chk($sformatf("%s%0d", name, k), 32'(ad[k]), exp);
      endcase
    end
  endtask

  task automatic begin_frame();
    @(posedge clk); #1;
    start = 1;
    in_valid = 0;
    mcnt = 0;
  endtask

  task automatic send(input logic [15:0] d, input bit gap,
                      input bit inj);
    @(posedge clk); #1;
    start = inj;
    frame_ack = inj;
    in_valid = 1;
    in_data = d;
    both("in_ready_load", 0, 1);
    q[1].push_back('{cyc + 1, rev8(mcnt[7:0]), d});
    q[0].push_back('{cyc + 1, mcnt[7:0], d});
    mcnt++;
    if (gap) begin
      @(posedge clk); #1;
      start = 0;
      frame_ack = 0;
      in_valid = 0;
      in_data = 16'hDEAD;
    end
  endtask

  task automatic frame_end(input int count, input bit ack_now);
    @(posedge clk); #1;
    start = 0;
    frame_ack = 0;
    in_valid = 0;
    both("in_ready_done", 0, 0);
    both("frame_ready_early", 1, 0);
    @(posedge clk); #1;
    both("frame_ready_rise", 1, 1);
    both("frame_count", 2, count);
    if (ack_now) frame_ack = 1;
    else start = 1;
    @(posedge clk); #1;
    frame_ack = 0;
    start = 0;
    if (!ack_now) begin
      both("frame_ready_hold", 1, 1);
      frame_ack = 1;
      @(posedge clk); #1;
      frame_ack = 0;
    end
    both("frame_ready_clear", 1, 0);
    both("in_ready_idle", 0, 0);
    both("frame_count_after", 2, count);
  endtask

  initial begin
    reset = 1;
    start = 0;
    in_valid = 0;
    in_data = 0;
    frame_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1;
    both("rst_in_ready", 0, 0);
    both("rst_frame_ready", 1, 0);
    both("rst_frame_count", 2, 0);
    both("rst_address", 3, 0);
    reset = 0;

    // Frame 1: back-to-back ramp; stray start/ack at sample 50.
    begin_frame();
    for (int i = 0; i < 256; i++) send(16'(i), 0, i == 50);
    frame_end(1, 0);

    // Frame 2: one-in-two valid, ack coincident with frame_ready.
    begin_frame();
    for (int i = 0; i < 256; i++) send(16'hA000 + 16'(i), i != 255, 0);
    frame_end(2, 1);

    // Frame 3: reset lands on the edge that would take sample 100.
    begin_frame();
    for (int i = 0; i < 100; i++) send(16'h0300 + 16'(i), 0, 0);
    @(posedge clk); #1;
    in_valid = 1;
    in_data = 16'hBEEF;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    in_valid = 0;
    both("mid_rst_in_ready", 0, 0);
    both("mid_rst_frame_ready", 1, 0);
    both("mid_rst_frame_count", 2, 0);
    both("mid_rst_address", 3, 0);
    repeat (5) @(posedge clk);
    #1;
    both("post_rst_in_ready", 0, 0);

    // Frame 4: full frame after the aborted one.
    begin_frame();
    for (int i = 0; i < 256; i++) send(16'h5000 + 16'(i), 0, 0);
    frame_end(1, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty1", 32'(q[1].size()), 0);
    chk("queue_empty0", 32'(q[0].size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
